// File: rtl/barrel_shift_pipe_pkg.sv
// Shared definitions for the pipelined barrel unit.
//   mode_e     : operation encoding carried down the pipe (rotate, logical, arithmetic, reserved)
//   is_rotate  : 1 when the mode performs a rotate (reserved decodes as rotate)
//   entry_fill : fill bit chosen once at pipe entry and carried to every stage
package barrel_shift_pipe_pkg;

  typedef enum logic [1:0] {
    ModeRot = 2'b00,
    ModeLsh = 2'b01,
    ModeAsh = 2'b10,
    ModeRsv = 2'b11
  } mode_e;

  function automatic logic is_rotate(input logic [1:0] mode);
    return (mode_e'(mode) == ModeRot) || (mode_e'(mode) == ModeRsv);
  endfunction

  // Only an arithmetic right shift replicates the sign bit. Left operations are done on the
  // reversed operand, so arithmetic-left fills with zero exactly like logical-left.
  function automatic logic entry_fill(input logic [1:0] mode, input logic left, input logic msb);
    return (mode_e'(mode) == ModeAsh) && !left && msb;
  endfunction

endpackage

// File: rtl/barrel_stage.sv
// One pipeline stage of the barrel unit: optionally right-shifts or right-rotates the operand by
// DIST bits and registers the result together with the beat's control fields.
//   clk_i, reset_ni : clock, synchronous active-low reset (clears every register)
//   load_i          : stage captures its input this cycle (empty, or downstream takes its beat)
//   valid_i         : incoming beat is real (0 loads a bubble)
//   data_i, amt_i, mode_i, left_i, fill_i : beat fields from the previous stage
//   shift_i         : amount bit selecting this stage's DIST move
//   *_o             : registered beat fields for the next stage
module barrel_stage
  import barrel_shift_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 3,
  parameter int unsigned DIST  = 1
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             load_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [AW-1:0]    amt_i,
  input  logic [1:0]       mode_i,
  input  logic             left_i,
  input  logic             fill_i,
  input  logic             shift_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [AW-1:0]    amt_o,
  output logic [1:0]       mode_o,
  output logic             left_o,
  output logic             fill_o
);

  logic [WIDTH-1:0] shifted;

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [AW-1:0]    amt_q;
  logic [1:0]       mode_q;
  logic             left_q;
  logic             fill_q;

  always_comb begin
    shifted = data_i;
    if (shift_i) begin
      if (is_rotate(mode_i)) begin
        shifted = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
      end else begin
        shifted = {{DIST{fill_i}}, data_i[WIDTH-1:DIST]};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      mode_q  <= '0;
      left_q  <= 1'b0;
      fill_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= valid_i;
      data_q  <= shifted;
      amt_q   <= amt_i;
      mode_q  <= mode_i;
      left_q  <= left_i;
      fill_q  <= fill_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign amt_o   = amt_q;
  assign mode_o  = mode_q;
  assign left_o  = left_q;
  assign fill_o  = fill_q;

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel unit: rotate, logical shift or arithmetic shift, left or right, by 0..WIDTH-1.
// Left operations reverse the operand on entry, run the right-direction op and reverse on exit.
// Stage k moves the operand by 2^k when amt[k] is set; the last stage register is the output.
//   clk, reset_n        : clock, synchronous active-low reset
//   in_valid/in_ready   : operand handshake; in_data operand, in_amt distance,
//                         in_mode (00 rot, 01 lsh, 10 ash, 11 = rot), in_left direction
//   out_valid/out_ready : result handshake; out_data result (held while stalled)
module barrel_shift_pipe
  import barrel_shift_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amt,
  input  logic [1:0]       in_mode,
  input  logic             in_left,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  if (((1 << AW) != WIDTH) || (WIDTH < 4)) begin : g_bad_params
    $error("barrel_shift_pipe: WIDTH must be a power of two >= 4 and AW = log2(WIDTH)");
  end

  // Index 0 is the entry point, index k+1 is the register of stage k.
  logic [AW:0]      s_valid;
  logic [WIDTH-1:0] s_data [AW+1];
  logic [AW-1:0]    s_amt  [AW+1];
  logic [1:0]       s_mode [AW+1];
  logic [AW:0]      s_left;
  logic [AW:0]      s_fill;

  logic [AW-1:0]    load;
  logic [WIDTH-1:0] in_rev;
  logic [WIDTH-1:0] out_rev;

  always_comb begin
    in_rev  = '0;
    out_rev = '0;
    for (int i = 0; i < WIDTH; i++) begin
      in_rev[i]  = in_data[WIDTH-1-i];
      out_rev[i] = s_data[AW][WIDTH-1-i];
    end
  end

  assign s_valid[0] = in_valid;
  assign s_data[0]  = in_left ? in_rev : in_data;
  assign s_amt[0]   = in_amt;
  assign s_mode[0]  = in_mode;
  assign s_left[0]  = in_left;
  assign s_fill[0]  = entry_fill(in_mode, in_left, in_data[WIDTH-1]);

  // Ready chain from the consumer back to stage 0: a stage loads when it is empty or its beat
  // is being taken downstream, so bubbles collapse instead of travelling to the output.
  always_comb begin : p_load
    logic take;
    load = '0;
    take = out_ready;
    for (int k = AW - 1; k >= 0; k--) begin
      load[k] = !s_valid[k+1] || take;
      take    = load[k];
    end
  end

  assign in_ready = reset_n && load[0];

  for (genvar k = 0; k < AW; k++) begin : g_stage
    barrel_stage #(
      .WIDTH (WIDTH),
      .AW    (AW),
      .DIST  (1 << k)
    ) u_stage (
      .clk_i    (clk),
      .reset_ni (reset_n),
      .load_i   (load[k]),
      .valid_i  (s_valid[k]),
      .data_i   (s_data[k]),
      .amt_i    (s_amt[k]),
      .mode_i   (s_mode[k]),
      .left_i   (s_left[k]),
      .fill_i   (s_fill[k]),
      .shift_i  (s_amt[k][k]),
      .valid_o  (s_valid[k+1]),
      .data_o   (s_data[k+1]),
      .amt_o    (s_amt[k+1]),
      .mode_o   (s_mode[k+1]),
      .left_o   (s_left[k+1]),
      .fill_o   (s_fill[k+1])
    );
  end

  assign out_valid = s_valid[AW];
  assign out_data  = s_left[AW] ? out_rev : s_data[AW];

  // Control fields of the last stage are not needed past the exit reverse.
  logic unused_tail;
  assign unused_tail = ^{s_amt[AW], s_mode[AW], s_fill[AW]};

endmodule
